rv_stream_monitor: RTL and testbench
====================================

Name: rv_stream_monitor

Overview:
- Synthesizable, parametrised ready/valid protocol monitor with deadlock watchdog for the out-of-order core.
- Observes NUM_CH handshake channels (fetch→decode, rename→skid, skid→dispatch, issue ports, ...).
- Per channel: flags payload changes while stalled and valid retraction before handshake.
- Watchdog: flags lack of forward progress while work is pending; captures first error (channel + cause) for debug/ILA readout.

Parameters:
NUM_CH, 4, number of monitored channels (>=1)
DATA_W, 32, payload width per channel
PROG_W, 4, width of auxiliary progress-event vector
STALL_LIMIT, 80, consecutive pending no-progress cycles before deadlock (>=2)
CHECK_DROP, 1, 1 enables valid-retraction check; 0 disables it
CH_W, $clog2(NUM_CH) min 1, derived channel index width
CNT_W, $clog2(STALL_LIMIT+1), derived watchdog counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  monitor enable; 0 = checks off, hold state and watchdog cleared
clear  in  1  synchronous clear of sticky flags and error capture
valid  in  NUM_CH  per-channel valid
ready  in  NUM_CH  per-channel ready
data  in  NUM_CH*DATA_W  payloads; channel i at [i*DATA_W +: DATA_W]
progress_in  in  PROG_W  extra progress events (FU done, ROB commit, mispredict)
busy_in  in  1  pipeline holds in-flight work even with no valid asserted
payload_err  out  NUM_CH  sticky: payload changed while held
drop_err  out  NUM_CH  sticky: valid retracted while held
deadlock  out  1  sticky watchdog trip
err_valid  out  1  first-error record valid
err_ch  out  CH_W  channel of first error (0 for deadlock)
err_code  out  2  01 payload, 10 drop, 11 deadlock
stall_ctr  out  CNT_W  current consecutive pending no-progress count

Behaviour:
- Reset (sync, active-high):
  - All outputs 0; all hold flags and hold registers 0.
  - Reset mid-stall discards hold state.
- Per channel i, when enable=1:
  - fire_i = valid_i & ready_i.
  - Stall with no hold: valid_i & !ready_i & !holding_i → capture data_i, holding_i=1 next cycle.
  - Payload check: holding_i & valid_i & (data_i != hold_i) → payload_err_i=1 next cycle. Applies on the firing cycle too.
  - Release: holding_i & fire_i → holding_i=0.
  - Drop check (CHECK_DROP=1 only): holding_i & !valid_i → drop_err_i=1, holding_i=0.
  - A fire with no prior hold never checks.
- Watchdog classification, each cycle:
  - progress = |fire | |progress_in → stall_ctr=0.
  - else pending = |valid | busy_in → stall_ctr+1, saturating at STALL_LIMIT.
  - else (idle) → stall_ctr=0.
  - deadlock=1 on the cycle after stall_ctr==STALL_LIMIT-1 with another pending cycle, i.e. stall_ctr reaches STALL_LIMIT.
- Error capture:
  - Latency: all error flags and the capture register update 1 cycle after the offending input cycle.
  - When err_valid=0 and any error detects, record it.
  - Priority: lowest channel index first; payload over drop (mutually exclusive per channel anyway); any channel error over deadlock.
  - The record holds until clear or reset.
- clear:
  - Zeroes payload_err, drop_err, deadlock, err_valid/err_ch/err_code.
  - Does not touch holding state or stall_ctr.
  - An error detected in the clear cycle is recorded; a new error wins over clear.
- enable=0:
  - No detection; holding cleared, stall_ctr=0.
  - Sticky flags keep their value.
- Errors are flags only; the monitor never backpressures or alters the monitored channels.

Optional Feature:
- RV_MON_PERF_EN defined:
  - Adds outputs fire_cnt (NUM_CH*32) and stall_cnt (NUM_CH*32).
  - Per-channel 32-bit wrapping counters of fire cycles and of valid&!ready cycles.
  - Counters count only when enable=1; zeroed by reset and by clear.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan (NUM_CH=3, DATA_W=8, STALL_LIMIT=4, CHECK_DROP=1):
- Ch1 valid=1 ready=0 data=0x5A for 3 cycles, then ready=1 → no errors, holding clears after fire.
- Ch0 stalled on 0x11, data→0x22 on 2nd stall cycle → payload_err=001 next cycle; err_valid=1, err_ch=0, err_code=01.
- Ch2 stalled on 0x33, then valid=0 without ready → drop_err=100, err_code=10. Repeat with CHECK_DROP=0 → no flag.
- Ch1 valid=1 ready=0 held constant, progress_in=0, busy_in=0 → stall_ctr 1,2,3,4; deadlock=1 after 4th cycle; err_code=11. Idle (all 0) for 10 cycles → stall_ctr stays 0, no deadlock.
- Same-cycle payload errors on ch2 and ch1 → err_ch=1, both payload_err bits set. Later clear together with a new ch0 drop → err_ch=0, err_code=10, other flags cleared.
- Reset asserted mid-stall on ch0, released; new data on the next stall → no false payload_err; all outputs 0 during reset. With RV_MON_PERF_EN, fire_cnt/stall_cnt match the directed counts.

Source files
------------

// File: rtl/rv_stream_monitor_if.sv
// rtl/rv_stream_monitor_if.sv - Ready/valid handshake bundle observed by rv_stream_monitor.
// Channel i occupies valid[i], ready[i] and data[i*DATA_W +: DATA_W].
interface rv_stream_monitor_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32
);
   logic [NUM_CH-1:0]        valid;
   logic [NUM_CH-1:0]        ready;
   logic [NUM_CH*DATA_W-1:0] data;

   modport master (output valid, output ready, output data);
   modport slave  (input valid, input ready, input data);
endinterface

// File: rtl/rv_stream_monitor.sv
// rtl/rv_stream_monitor.sv - Ready/valid protocol monitor with deadlock watchdog and first-error capture.
// Defining RV_MON_PERF_EN adds per-channel fire/stall cycle counters (fire_cnt, stall_cnt).
module rv_stream_monitor #(
   parameter int NUM_CH      = 4,
   parameter int DATA_W      = 32,
   parameter int PROG_W      = 4,
   parameter int STALL_LIMIT = 80,
   parameter int CHECK_DROP  = 1,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int CNT_W       = $clog2(STALL_LIMIT + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   clear,
   rv_stream_monitor_if.slave     ch,
   input  logic [PROG_W-1:0]      progress_in,
   input  logic                   busy_in,
   output logic [NUM_CH-1:0]      payload_err,
   output logic [NUM_CH-1:0]      drop_err,
   output logic                   deadlock,
   output logic                   err_valid,
   output logic [CH_W-1:0]        err_ch,
   output logic [1:0]             err_code,
   output logic [CNT_W-1:0]       stall_ctr
`ifdef RV_MON_PERF_EN
   ,
   output logic [NUM_CH*32-1:0]   fire_cnt,
   output logic [NUM_CH*32-1:0]   stall_cnt
`endif
);

   logic [NUM_CH-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] hold_data_q [NUM_CH];
   logic [DATA_W-1:0] hold_data_d [NUM_CH];
   logic [NUM_CH-1:0] payload_err_q, payload_err_d;
   logic [NUM_CH-1:0] drop_err_q, drop_err_d;
   logic              deadlock_q, deadlock_d;
   logic              err_valid_q, err_valid_d;
   logic [CH_W-1:0]   err_ch_q, err_ch_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [CNT_W-1:0]  stall_ctr_q, stall_ctr_d;

   logic [NUM_CH-1:0] fire, pay_det, drop_det;
   logic              progress, pending, dl_det, keep, cap_found;
   logic [CH_W-1:0]   cap_ch;
   logic [1:0]        cap_code;

   always_comb begin
      fire        = ch.valid & ch.ready;
      progress    = (|fire) | (|progress_in);
      pending     = (|ch.valid) | busy_in;
      hold_d      = hold_q;
      hold_data_d = hold_data_q;
      pay_det     = '0;
      drop_det    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!enable) begin
            hold_d[i] = 1'b0;
         end else if (hold_q[i]) begin
            pay_det[i]  = ch.valid[i] && (ch.data[i*DATA_W +: DATA_W] != hold_data_q[i]);
            drop_det[i] = (CHECK_DROP != 0) && !ch.valid[i];
            // A retracted beat ends the hold even when it is not flagged.
            if (fire[i] || !ch.valid[i]) hold_d[i] = 1'b0;
         end else if (ch.valid[i] && !ch.ready[i]) begin
            hold_d[i]      = 1'b1;
            hold_data_d[i] = ch.data[i*DATA_W +: DATA_W];
         end
      end

      dl_det      = 1'b0;
      stall_ctr_d = '0;
      if (enable && !progress && pending) begin
         dl_det      = (stall_ctr_q == CNT_W'(STALL_LIMIT - 1));
         stall_ctr_d = (stall_ctr_q == CNT_W'(STALL_LIMIT)) ? stall_ctr_q : stall_ctr_q + CNT_W'(1);
      end

      // Descending scan so the lowest channel, and payload over drop, is left standing.
      cap_found = dl_det;
      cap_ch    = '0;
      cap_code  = dl_det ? 2'b11 : 2'b00;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (drop_det[i]) begin
            cap_found = 1'b1;
            cap_ch    = CH_W'(i);
            cap_code  = 2'b10;
         end
         if (pay_det[i]) begin
            cap_found = 1'b1;
            cap_ch    = CH_W'(i);
            cap_code  = 2'b01;
         end
      end

      keep          = err_valid_q && !clear;
      payload_err_d = (clear ? '0 : payload_err_q) | pay_det;
      drop_err_d    = (clear ? '0 : drop_err_q) | drop_det;
      deadlock_d    = (deadlock_q && !clear) || dl_det;
      err_valid_d   = keep;
      err_ch_d      = keep ? err_ch_q : '0;
      err_code_d    = keep ? err_code_q : 2'b00;
      if (!keep && cap_found) begin
         err_valid_d = 1'b1;
         err_ch_d    = cap_ch;
         err_code_d  = cap_code;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q        <= '0;
         payload_err_q <= '0;
         drop_err_q    <= '0;
         deadlock_q    <= 1'b0;
         err_valid_q   <= 1'b0;
         err_ch_q      <= '0;
         err_code_q    <= 2'b00;
         stall_ctr_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) hold_data_q[i] <= '0;
      end else begin
         hold_q        <= hold_d;
         payload_err_q <= payload_err_d;
         drop_err_q    <= drop_err_d;
         deadlock_q    <= deadlock_d;
         err_valid_q   <= err_valid_d;
         err_ch_q      <= err_ch_d;
         err_code_q    <= err_code_d;
         stall_ctr_q   <= stall_ctr_d;
         for (int i = 0; i < NUM_CH; i++) hold_data_q[i] <= hold_data_d[i];
      end
   end

   assign payload_err = payload_err_q;
   assign drop_err    = drop_err_q;
   assign deadlock    = deadlock_q;
   assign err_valid   = err_valid_q;
   assign err_ch      = err_ch_q;
   assign err_code    = err_code_q;
   assign stall_ctr   = stall_ctr_q;

`ifdef RV_MON_PERF_EN
   logic [31:0] fire_cnt_q  [NUM_CH];
   logic [31:0] stall_cnt_q [NUM_CH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset || clear) begin
            fire_cnt_q[i]  <= '0;
            stall_cnt_q[i] <= '0;
         end else if (enable) begin
            fire_cnt_q[i]  <= fire_cnt_q[i] + {31'd0, fire[i]};
            stall_cnt_q[i] <= stall_cnt_q[i] + {31'd0, ch.valid[i] & ~ch.ready[i]};
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_perf
      assign fire_cnt[g*32 +: 32]  = fire_cnt_q[g];
      assign stall_cnt[g*32 +: 32] = stall_cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_rv_stream_monitor.sv
// tb/tb_rv_stream_monitor.sv - Directed and randomised checks of rv_stream_monitor against a behavioural model.
// Instance 0 has drop checking enabled, instance 1 has it disabled; both see the same bus.
module tb_rv_stream_monitor;
   localparam int NC  = 3;
   localparam int DW  = 8;
   localparam int PW  = 4;
   localparam int LIM = 4;
   localparam int CW  = 2;
   localparam int KW  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, enable, clear, busy_in;
   logic [PW-1:0] progress_in;
   rv_stream_monitor_if #(.NUM_CH(NC), .DATA_W(DW)) bus ();

   logic [NC-1:0] o_pe    [2];
   logic [NC-1:0] o_de    [2];
   logic          o_dl    [2];
   logic          o_ev    [2];
   logic [CW-1:0] o_ech   [2];
   logic [1:0]    o_ecode [2];
   logic [KW-1:0] o_ctr   [2];
`ifdef RV_MON_PERF_EN
   logic [NC*32-1:0] o_fc [2];
   logic [NC*32-1:0] o_sc [2];
`endif

   for (genvar k = 0; k < 2; k++) begin : g_dut
      rv_stream_monitor #(
         .NUM_CH(NC), .DATA_W(DW), .PROG_W(PW), .STALL_LIMIT(LIM), .CHECK_DROP(k == 0 ? 1 : 0)
      ) u_dut (
         .clk(clk), .reset(reset), .enable(enable), .clear(clear), .ch(bus),
         .progress_in(progress_in), .busy_in(busy_in),
         .payload_err(o_pe[k]), .drop_err(o_de[k]), .deadlock(o_dl[k]),
         .err_valid(o_ev[k]), .err_ch(o_ech[k]), .err_code(o_ecode[k]), .stall_ctr(o_ctr[k])
`ifdef RV_MON_PERF_EN
         , .fire_cnt(o_fc[k]), .stall_cnt(o_sc[k])
`endif
      );
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   // Model: held beat value per channel (-1 when no beat is waiting), run length of stalled-pending cycles.
   typedef struct { int ch; int code; } err_t;
   int          m_held  [2][NC];
   bit          m_pe    [2][NC];
   bit          m_de    [2][NC];
   bit          m_dl    [2];
   bit          m_ev    [2];
   int          m_run   [2];
   int          m_ech   [2];
   int          m_ecode [2];
   logic [31:0] m_fc    [NC];
   logic [31:0] m_sc    [NC];
   bit          started = 1'b0;

   always @(posedge clk) begin : model
      err_t q[$];
      err_t e;
      bit   prog, pend;
      int   d;
      started = 1'b1;
      prog = ((bus.valid & bus.ready) != 0) || (progress_in != 0);
      pend = (bus.valid != 0) || busy_in;
      for (int k = 0; k < 2; k++) begin
         q.delete();
         if (reset) begin
            for (int c = 0; c < NC; c++) begin
               m_held[k][c] = -1; m_pe[k][c] = 0; m_de[k][c] = 0;
            end
            m_dl[k] = 0; m_ev[k] = 0; m_run[k] = 0; m_ech[k] = 0; m_ecode[k] = 0;
         end else begin
            for (int c = 0; c < NC; c++) begin
               d = int'(bus.data[c*DW +: DW]);
               if (enable && m_held[k][c] >= 0) begin
                  e.ch = c;
                  if (bus.valid[c] && d != m_held[k][c]) begin e.code = 1; q.push_back(e); end
                  else if (!bus.valid[c] && k == 0) begin e.code = 2; q.push_back(e); end
               end
            end
            if (enable && !prog && pend && m_run[k] == LIM - 1) begin
               e.ch = 0; e.code = 3; q.push_back(e);
            end
            m_run[k] = (!enable || prog || !pend) ? 0 : ((m_run[k] < LIM) ? m_run[k] + 1 : LIM);
            for (int c = 0; c < NC; c++) begin
               d = int'(bus.data[c*DW +: DW]);
               if (!enable) m_held[k][c] = -1;
               else if (m_held[k][c] >= 0) begin
                  if (!bus.valid[c] || bus.ready[c]) m_held[k][c] = -1;
               end else if (bus.valid[c] && !bus.ready[c]) m_held[k][c] = d;
            end
            if (clear) begin
               for (int c = 0; c < NC; c++) begin m_pe[k][c] = 0; m_de[k][c] = 0; end
               m_dl[k] = 0; m_ev[k] = 0; m_ech[k] = 0; m_ecode[k] = 0;
            end
            foreach (q[j]) begin
               if (q[j].code == 1) m_pe[k][q[j].ch] = 1;
               else if (q[j].code == 2) m_de[k][q[j].ch] = 1;
               else m_dl[k] = 1;
            end
            if (!m_ev[k] && q.size() > 0) begin
               m_ev[k] = 1; m_ech[k] = q[0].ch; m_ecode[k] = q[0].code;
            end
         end
      end
      for (int c = 0; c < NC; c++) begin
         if (reset || clear) begin m_fc[c] = 0; m_sc[c] = 0; end
         else if (enable) begin
            m_fc[c] = m_fc[c] + ((bus.valid[c] && bus.ready[c]) ? 32'd1 : 32'd0);
            m_sc[c] = m_sc[c] + ((bus.valid[c] && !bus.ready[c]) ? 32'd1 : 32'd0);
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [NC-1:0] epe, ede;
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NC; c++) begin epe[c] = m_pe[k][c]; ede[c] = m_de[k][c]; end
            chk($sformatf("payload_err[%0d]", k), o_pe[k], epe);
            chk($sformatf("drop_err[%0d]", k), o_de[k], ede);
            chk($sformatf("deadlock[%0d]", k), o_dl[k], m_dl[k]);
            chk($sformatf("err_valid[%0d]", k), o_ev[k], m_ev[k]);
            chk($sformatf("err_ch[%0d]", k), o_ech[k], m_ech[k]);
            chk($sformatf("err_code[%0d]", k), o_ecode[k], m_ecode[k]);
            chk($sformatf("stall_ctr[%0d]", k), o_ctr[k], m_run[k]);
`ifdef RV_MON_PERF_EN
            for (int c = 0; c < NC; c++) begin
               chk($sformatf("fire_cnt[%0d][%0d]", k, c), o_fc[k][c*32 +: 32], m_fc[c]);
               chk($sformatf("stall_cnt[%0d][%0d]", k, c), o_sc[k][c*32 +: 32], m_sc[c]);
            end
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ch(int c, bit v, bit r, logic [7:0] d);
      bus.valid[c] = v;
      bus.ready[c] = r;
      bus.data[c*DW +: DW] = d;
   endtask

   task automatic idle(int n);
      bus.valid = '0;
      bus.ready = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; clear = 1'b0; busy_in = 1'b0; progress_in = '0;
      bus.valid = '0; bus.ready = '0; bus.data = '0;
      tick(); tick(); tick();
      chk("reset_err_valid", o_ev[0], 0);
      chk("reset_stall_ctr", o_ctr[0], 0);
      chk("reset_payload_err", o_pe[0], 0);
      reset = 1'b0;

      // Clean stall then fire
      pulse_clear();
      set_ch(1, 1, 0, 8'h5A);
      tick(); tick(); tick();
      chk("t1_stall_ctr", o_ctr[0], 3);
      set_ch(1, 1, 1, 8'h5A);
      tick();
      chk("t1_payload_err", o_pe[0], 0);
      chk("t1_err_valid", o_ev[0], 0);
      chk("t1_stall_ctr_fire", o_ctr[0], 0);
`ifdef RV_MON_PERF_EN
      chk("t1_fire_cnt", o_fc[0][63:32], 1);
      chk("t1_stall_cnt", o_sc[0][63:32], 3);
`endif
      idle(1);

      // Payload change while stalled
      pulse_clear();
      set_ch(0, 1, 0, 8'h11); tick();
      set_ch(0, 1, 0, 8'h22); tick();
      chk("t2_payload_err", o_pe[0], 3'b001);
      chk("t2_err_valid", o_ev[0], 1);
      chk("t2_err_ch", o_ech[0], 0);
      chk("t2_err_code", o_ecode[0], 2'b01);
      set_ch(0, 1, 1, 8'h22); tick();
      idle(1);

      // Valid retraction
      pulse_clear();
      set_ch(2, 1, 0, 8'h33); tick();
      set_ch(2, 0, 0, 8'h33); tick();
      chk("t3_drop_err", o_de[0], 3'b100);
      chk("t3_err_code", o_ecode[0], 2'b10);
      chk("t3_err_ch", o_ech[0], 2);
      chk("t3_nodrop_drop_err", o_de[1], 0);
      chk("t3_nodrop_err_valid", o_ev[1], 0);
      idle(1);

      // Watchdog trip and saturation
      pulse_clear();
      set_ch(1, 1, 0, 8'h77);
      for (int n = 1; n <= 4; n++) begin
         tick();
         chk($sformatf("t4_stall_ctr_%0d", n), o_ctr[0], n);
      end
      chk("t4_deadlock", o_dl[0], 1);
      chk("t4_err_code", o_ecode[0], 2'b11);
      chk("t4_err_ch", o_ech[0], 0);
      tick();
      chk("t4_stall_ctr_sat", o_ctr[0], 4);
      set_ch(1, 1, 1, 8'h77); tick();
      set_ch(1, 0, 0, 8'h00);
      pulse_clear();
      idle(10);
      chk("t4_idle_stall_ctr", o_ctr[0], 0);
      chk("t4_idle_deadlock", o_dl[0], 0);

      // Simultaneous payload errors, then clear racing a new drop
      pulse_clear();
      set_ch(1, 1, 0, 8'h10); set_ch(2, 1, 0, 8'h20); tick();
      set_ch(1, 1, 0, 8'h11); set_ch(2, 1, 0, 8'h21); tick();
      chk("t5_payload_err", o_pe[0], 3'b110);
      chk("t5_err_ch", o_ech[0], 1);
      chk("t5_err_code", o_ecode[0], 2'b01);
      set_ch(1, 1, 1, 8'h11); set_ch(2, 1, 1, 8'h21); tick();
      set_ch(1, 0, 0, 8'h00); set_ch(2, 0, 0, 8'h00);
      set_ch(0, 1, 0, 8'h40); tick();
      set_ch(0, 0, 0, 8'h40); clear = 1'b1; tick(); clear = 1'b0;
      chk("t5_clear_err_ch", o_ech[0], 0);
      chk("t5_clear_err_code", o_ecode[0], 2'b10);
      chk("t5_clear_payload_err", o_pe[0], 0);
      chk("t5_clear_drop_err", o_de[0], 3'b001);
      idle(1);

      // Reset in the middle of a stall
      set_ch(0, 1, 0, 8'h44); tick(); tick();
      reset = 1'b1; tick();
      chk("t6_reset_stall_ctr", o_ctr[0], 0);
      chk("t6_reset_err_valid", o_ev[0], 0);
      chk("t6_reset_drop_err", o_de[0], 0);
      reset = 1'b0;
      set_ch(0, 1, 0, 8'h55); tick(); tick();
      chk("t6_payload_err", o_pe[0], 0);
      chk("t6_err_valid", o_ev[0], 0);
      set_ch(0, 1, 1, 8'h55); tick();
      idle(1);

      // Disabled monitor
      enable = 1'b0;
      set_ch(1, 1, 0, 8'h12); tick(); tick(); tick();
      chk("t7_disabled_stall_ctr", o_ctr[0], 0);
      set_ch(1, 0, 0, 8'h00);
      enable = 1'b1;
      tick();
      chk("t7_reenable_drop_err", o_de[0], 0);

      for (int n = 0; n < 3000; n++) begin
         logic [7:0] cur;
         reset       = ($urandom_range(0, 199) == 0);
         clear       = ($urandom_range(0, 39) == 0);
         enable      = ($urandom_range(0, 15) != 0);
         busy_in     = ($urandom_range(0, 9) == 0);
         progress_in = ($urandom_range(0, 11) == 0) ? PW'($urandom_range(1, 15)) : '0;
         for (int c = 0; c < NC; c++) begin
            cur = bus.data[c*DW +: DW];
            if ($urandom_range(0, 4) == 0) cur = 8'($urandom_range(0, 3));
            set_ch(c, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, cur);
         end
         tick();
      end

      reset = 1'b0; clear = 1'b0; enable = 1'b1; busy_in = 1'b0; progress_in = '0;
      idle(2);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
